// File: rtl/sprite_pkg.sv
// sprite_pkg: shared constants and FSM state encodings for the sprite shape reader
package sprite_pkg;
  localparam int NUM_LEVELS = 64;
  localparam int SPRITE_ROWS = 16;
  localparam int H_ACTIVE = 640;
  localparam int V_LAST = 524;
  localparam int ID_W = 6;
  localparam int Y_W = 10;
  localparam int ROW_W = 16;
  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    WAIT_HB = 4'd1,
    CHECK   = 4'd2,
    FETCH   = 4'd3,
    STORE   = 4'd4,
    SKIP    = 4'd5,
    DONE    = 4'd6
  } state_t;
endpackage

// File: rtl/sprite_row_select.sv
// sprite_row_select: per-level next-line row, in-range flag and shape RAM address
module sprite_row_select import sprite_pkg::*; (
  input  logic [5:0]                 level,
  input  logic [NUM_LEVELS*ID_W-1:0] sprite_id,
  input  logic [NUM_LEVELS*Y_W-1:0]  sprite_y,
  input  logic [Y_W-1:0]             v_pos,
  output logic                       in_range,
  output logic [15:0]                addr
);
  logic [ID_W-1:0] id;
  logic [Y_W-1:0] y, vn, row;
  always_comb begin
    id = sprite_id[ID_W*level +: ID_W];
    y = sprite_y[Y_W*level +: Y_W];
    vn = (v_pos == Y_W'(V_LAST)) ? '0 : v_pos + 1'b1;
    row = vn - y;
    in_range = row < Y_W'(SPRITE_ROWS);
    addr = {6'b0, id, row[3:0]};
  end
endmodule

// File: rtl/sprite_shape_reader.sv
// sprite_shape_reader: blanking-time fetch of 64 sprite rows; SHAPE_DBUF_EN adds an atomic shadow buffer
module sprite_shape_reader import sprite_pkg::*; (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [6:0]                    level_counter,
  input  logic [15:0]                   data_in,
  input  logic [NUM_LEVELS*ID_W-1:0]    sprite_id,
  input  logic [NUM_LEVELS*Y_W-1:0]     sprite_y,
  input  logic [9:0]                    V_pos_in,
  input  logic [9:0]                    H_pos_in,
  output logic [NUM_LEVELS*ROW_W-1:0]   sprite_shape_out,
  output logic                          wren_out,
  output logic [15:0]                   addr_out,
  output logic                          level_counter_enable,
  output logic                          level_counter_reset,
  output logic [3:0]                    EstadoAtual_FSM1
);
  state_t state, next;
  logic in_range, slot_we, h_blank;
  logic [15:0] addr;
  logic [ROW_W-1:0] slot_val;
  logic [5:0] lvl;
  sprite_row_select u_sel (
    .level    (level_counter[5:0]),
    .sprite_id(sprite_id),
    .sprite_y (sprite_y),
    .v_pos    (V_pos_in),
    .in_range (in_range),
    .addr     (addr)
  );
  always_comb begin
    h_blank = H_pos_in >= 10'(H_ACTIVE);
    next = IDLE;
    case (state)
      IDLE:        next = h_blank ? IDLE : WAIT_HB;
      WAIT_HB:     next = h_blank ? CHECK : WAIT_HB;
      CHECK:       next = level_counter[6] ? DONE : in_range ? FETCH : SKIP;
      FETCH:       next = STORE;
      STORE, SKIP: next = CHECK;
      DONE:        next = h_blank ? DONE : WAIT_HB;
      default:     next = IDLE;
    endcase
  end
  assign lvl = level_counter[5:0];
  assign slot_we = state == STORE || state == SKIP;
  assign slot_val = state == STORE ? data_in : '0;
  assign wren_out = 1'b0;
  assign level_counter_enable = slot_we;
  assign level_counter_reset = state == IDLE || state == WAIT_HB;
  assign EstadoAtual_FSM1 = state;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      addr_out <= '0;
    end else begin
      state <= next;
      if (state == CHECK && !level_counter[6] && in_range) addr_out <= addr;
    end
  end
`ifdef SHAPE_DBUF_EN
  logic [NUM_LEVELS*ROW_W-1:0] shadow;
  // shadow is stable throughout DONE, so reloading every DONE cycle equals a single load on entry
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
      sprite_shape_out <= '0;
    end else begin
      if (slot_we) shadow[ROW_W*lvl +: ROW_W] <= slot_val;
      if (state == DONE) sprite_shape_out <= shadow;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) sprite_shape_out <= '0;
    else if (slot_we) sprite_shape_out[ROW_W*lvl +: ROW_W] <= slot_val;
  end
`endif
endmodule

// File: tb/tb_sprite_shape_reader.sv
// tb_sprite_shape_reader: scoreboard bench with level counter and shape RAM models
module tb_sprite_shape_reader;
  logic clk = 0, rst = 1;
  logic [6:0] level_counter;
  logic [15:0] data_in;
  logic [383:0] sprite_id;
  logic [639:0] sprite_y;
  logic [9:0] V_pos_in = 0, H_pos_in = 0;
  logic [1023:0] sprite_shape_out;
  logic wren_out, level_counter_enable, level_counter_reset;
  logic [15:0] addr_out;
  logic [3:0] state;
  logic [15:0] ram [0:65535];
  int n_checks = 0, n_fail = 0;
  logic [1023:0] exp_q[$];
  int cyc_q[$];
  int fetch_addr[64];
  bit fetched[64];
  sprite_shape_reader dut (
    .clk(clk), .rst(rst), .level_counter(level_counter), .data_in(data_in),
    .sprite_id(sprite_id), .sprite_y(sprite_y), .V_pos_in(V_pos_in), .H_pos_in(H_pos_in),
    .sprite_shape_out(sprite_shape_out), .wren_out(wren_out), .addr_out(addr_out),
    .level_counter_enable(level_counter_enable), .level_counter_reset(level_counter_reset),
    .EstadoAtual_FSM1(state)
  );
  always #10 clk = ~clk;
  assign data_in = ram[addr_out];
  always @(posedge clk)
    if (level_counter_reset) level_counter <= 0;
    else if (level_counter_enable) level_counter <= level_counter + 1;
  task automatic check(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic set_level(input int l, input logic [5:0] id, input logic [9:0] y);
    sprite_id[6*l +: 6] = id;
    sprite_y[10*l +: 10] = y;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic predict(input int v);
    logic [9:0] vn, row;
    logic [1023:0] e = '0;
    int n = 0;
    vn = (v == 524) ? 10'd0 : 10'(v + 1);
    for (int l = 0; l < 64; l++) begin
      row = vn - sprite_y[10*l +: 10];
      if (row < 16) begin
        e[16*l +: 16] = ram[{6'b0, sprite_id[6*l +: 6], row[3:0]}];
        n++;
      end
    end
    exp_q.push_back(e);
    cyc_q.push_back(130 + n);
  endtask
  task automatic run_line(input int v);
    int cyc = 0, en = 0;
    bit started = 0, ok = 0;
    predict(v);
    for (int l = 0; l < 64; l++) fetched[l] = 0;
    V_pos_in = 10'(v);
    H_pos_in = 0;
    repeat (2) tick();
    H_pos_in = 640;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (state == 2) started = 1;
      if (started) cyc++;
      if (level_counter_enable) en++;
      if (state == 4) begin
        fetched[level_counter[5:0]] = 1;
        fetch_addr[level_counter[5:0]] = int'(addr_out);
      end
      if (state == 6) begin
        ok = 1;
        break;
      end
    end
    check("scan_done", ok, 1);
    tick();
    check("shape", sprite_shape_out, exp_q.pop_front());
    check("cycles", cyc, cyc_q.pop_front());
    check("enables", en, 64);
    H_pos_in = 0;
  endtask
  initial begin
    bit ok = 0;
    for (int i = 0; i < 65536; i++)
      ram[i] = (i >= 16 && i < 32) ? 16'hFFFF : (i >= 80 && i < 96) ? 16'(16'hA500 + i - 80) : 16'h0;
    for (int l = 0; l < 64; l++) set_level(l, 0, 1000);
    rst = 1;
    repeat (2) tick();
    check("rst_state", state, 0);
    check("rst_shape", sprite_shape_out, 0);
    check("rst_addr", addr_out, 0);
    check("rst_wren", wren_out, 0);
    check("rst_lce", level_counter_enable, 0);
    check("rst_lcr", level_counter_reset, 1);
    rst = 0;
    set_level(60, 1, 36);
    set_level(61, 2, 34);
    set_level(62, 3, 35);
    set_level(63, 4, 33);
    set_level(59, 0, 37);
    run_line(35);
    check("l60_addr35", fetch_addr[60], 16);
    check("l60_row35", sprite_shape_out[975:960], 16'hFFFF);
    check("l61_addr", fetch_addr[61], 34);
    check("l62_addr", fetch_addr[62], 49);
    check("l63_addr", fetch_addr[63], 67);
    check("l61_63_rows", sprite_shape_out[1023:976], 0);
    run_line(36);
    check("l59_addr", fetch_addr[59], 0);
    check("l59_row", sprite_shape_out[959:944], 0);
    check("l60_addr36", fetch_addr[60], 17);
    run_line(50);
    check("l60_addr50", fetch_addr[60], 31);
    check("l60_row50", sprite_shape_out[975:960], 16'hFFFF);
    run_line(51);
    check("l60_nofetch", fetched[60], 0);
    check("l60_row51", sprite_shape_out[975:960], 0);
    run_line(200);
    set_level(10, 5, 0);
    run_line(524);
    check("wrap_addr", fetch_addr[10], 80);
    check("wrap_row", sprite_shape_out[175:160], 16'hA500);
    set_level(10, 5, 1020);
    run_line(1);
    check("wrap10_addr", fetch_addr[10], 86);
    check("wrap10_row", sprite_shape_out[175:160], 16'hA506);
    set_level(10, 0, 1000);
    run_line(35);
    V_pos_in = 35;
    H_pos_in = 0;
    repeat (2) tick();
    H_pos_in = 640;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (state == 3) begin
        ok = 1;
        break;
      end
    end
    check("reach_fetch", ok, 1);
    rst = 1;
    tick();
    check("mid_rst_state", state, 0);
    check("mid_rst_shape", sprite_shape_out, 0);
    check("mid_rst_lcr", level_counter_reset, 1);
    rst = 0;
    run_line(35);
    check("rescan_row", sprite_shape_out[975:960], 16'hFFFF);
    for (int l = 0; l < 64; l++) set_level(l, 1, 100);
    run_line(99);
    check("worst_row0", sprite_shape_out[15:0], 16'hFFFF);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
